seq_pattern_gen: RTL

SEQ_PATTERN_GEN -- requirements
Module: seq_pattern_gen

---
 rtl/seq_gen_pkg.sv | 21 ++
 rtl/seq_pattern_gen.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/seq_gen_pkg.sv
// Shared definitions for the serial pattern generator and the sequence detector benches:
// FSM state encodings, the default pattern and the repeat-count helper.
package seq_gen_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    SHIFT = 3'b001,
    GAP   = 3'b010,
    DONE  = 3'b011
  } state_t;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b1001;
  localparam int         FRAME_CNT_W     = 8;
  localparam int         BIT_CNT_W       = 4;

  // A repeat request of zero still emits one frame.
  function automatic logic [FRAME_CNT_W-1:0] frames_from_repeat(input logic [FRAME_CNT_W-1:0] req);
    return (req == '0) ? FRAME_CNT_W'(1) : req;
  endfunction

endpackage

// File: rtl/seq_pattern_gen.sv
// Serial pattern generator: emits a burst of MSB-first frames with optional idle gaps.
// Optional macro SEQ_GEN_ABORT_EN adds an i_abort input that cancels a running burst.
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int                 P_WIDTH   = 4,
  parameter logic [P_WIDTH-1:0] P_PATTERN = DEFAULT_PATTERN,
  parameter int                 P_GAP     = 0
) (
  input  logic               i_clk,
  input  logic               i_reset,
`ifdef SEQ_GEN_ABORT_EN
  input  logic               i_abort,
`endif
  input  logic               i_start,
  input  logic               i_use_ext,
  input  logic [P_WIDTH-1:0] i_pattern,
  input  logic [7:0]         i_repeat,
  output logic               o_x,
  output logic               o_valid,
  output logic               o_busy,
  output logic               o_done
);

  localparam int                   MSB      = P_WIDTH - 1;
  localparam logic [BIT_CNT_W-1:0] BIT_LOAD = BIT_CNT_W'(P_WIDTH - 1);
  localparam logic [BIT_CNT_W-1:0] GAP_LOAD = BIT_CNT_W'((P_GAP > 0) ? (P_GAP - 1) : 0);
  localparam logic                 HAS_GAP  = (P_GAP > 0);

  state_t                   state;
  logic [P_WIDTH-1:0]       shift_reg;
  logic [P_WIDTH-1:0]       pattern_reg;
  logic [BIT_CNT_W-1:0]     bit_cnt;
  logic [BIT_CNT_W-1:0]     gap_cnt;
  logic [FRAME_CNT_W-1:0]   frame_cnt;
  logic [P_WIDTH-1:0]       start_pattern;
  logic                     abort_req;

  assign start_pattern = i_use_ext ? i_pattern : P_PATTERN;

`ifdef SEQ_GEN_ABORT_EN
  assign abort_req = i_abort;
`else
  assign abort_req = 1'b0;
`endif

  // Outputs are registered alongside the state so every output follows the state it belongs to.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= IDLE;
      shift_reg   <= '0;
      pattern_reg <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      frame_cnt   <= '0;
      o_x         <= 1'b0;
      o_valid     <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_start) begin
            state       <= SHIFT;
            pattern_reg <= start_pattern;
            shift_reg   <= start_pattern;
            bit_cnt     <= BIT_LOAD;
            frame_cnt   <= frames_from_repeat(i_repeat);
            o_x         <= start_pattern[MSB];
            o_valid     <= 1'b1;
            o_busy      <= 1'b1;
          end
        end

        SHIFT: begin
          if (abort_req) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            frame_cnt <= '0;
            o_x       <= 1'b0;
            o_valid   <= 1'b0;
            o_busy    <= 1'b0;
          end else if (bit_cnt != '0) begin
            shift_reg <= {shift_reg[MSB-1:0], 1'b0};
            bit_cnt   <= bit_cnt - BIT_CNT_W'(1);
            o_x       <= shift_reg[MSB-1];
          end else if (frame_cnt > FRAME_CNT_W'(1)) begin
            frame_cnt <= frame_cnt - FRAME_CNT_W'(1);
            if (HAS_GAP) begin
              state   <= GAP;
              gap_cnt <= GAP_LOAD;
              o_x     <= 1'b0;
              o_valid <= 1'b0;
            end else begin
              shift_reg <= pattern_reg;
              bit_cnt   <= BIT_LOAD;
              o_x       <= pattern_reg[MSB];
            end
          end else begin
            state   <= DONE;
            o_x     <= 1'b0;
            o_valid <= 1'b0;
            o_done  <= 1'b1;
          end
        end

        GAP: begin
          if (abort_req) begin
            state     <= IDLE;
            gap_cnt   <= '0;
            frame_cnt <= '0;
            o_x       <= 1'b0;
            o_valid   <= 1'b0;
            o_busy    <= 1'b0;
          end else if (gap_cnt == '0) begin
            state     <= SHIFT;
            shift_reg <= pattern_reg;
            bit_cnt   <= BIT_LOAD;
            o_x       <= pattern_reg[MSB];
            o_valid   <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - BIT_CNT_W'(1);
          end
        end

        DONE: begin
          state  <= IDLE;
          o_done <= 1'b0;
          o_busy <= 1'b0;
        end

        default: begin
          state   <= IDLE;
          o_x     <= 1'b0;
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
          o_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
